wishbone_bus_arb_tmo: RTL
=========================

Name: wishbone_bus_arb_tmo

Overview:
- Next-generation parametrised Wishbone shared bus: M masters, S slaves, registered arbitration with selectable policy.
- Burst-aware grant hold (CTI/BTE), bus watchdog timeout, and unmapped-address error response.
- Sits between processor/DMA/NI masters and tile peripherals.
- Address decode stays external: the bus exports the granted address and takes back a one-hot slave select.

Parameters:
- M, 4, number of master ports (>=1)
- S, 4, number of slave ports (>=1)
- Dw, 32, data width
- Aw, 32, address width
- SELw, 4, byte-select width
- TAGw, 3, merged {tga,tgb,tgc} width
- CTIw, 3, cycle-type width
- BTEw, 2, burst-type width
- ARB_MODE, "RR", "RR" round-robin or "FIXED" (lowest index wins)
- TIMEOUT, 255, cycles with stb and no response before the bus errors; 0 disables the watchdog
- TMOw, 8, watchdog counter width; requires TIMEOUT < 2**TMOw

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-low reset
- s_adr_o_all / s_dat_o_all / s_sel_o_all / s_tag_o_all / s_cti_o_all / s_bte_o_all, out, field*S, granted master's fields replicated per slave
- s_we_o_all / s_cyc_o_all / s_stb_o_all, out, S, write enable / cycle / strobe per slave
- s_dat_i_all, in, Dw*S, slave read data
- s_ack_i_all / s_err_i_all / s_rty_i_all, in, S, slave responses
- m_adr_i_all / m_dat_i_all / m_sel_i_all / m_tag_i_all / m_cti_i_all / m_bte_i_all, in, field*M, master request fields
- m_we_i_all / m_stb_i_all / m_cyc_i_all, in, M, master write enable / strobe / cycle
- m_dat_o_all, out, Dw*M, read data broadcast to all masters
- m_ack_o_all / m_err_o_all / m_rty_o_all, out, M, responses routed to the granted master only
- m_grant_addr, out, Aw, granted address, to the external decoder
- s_sel_one_hot, in, S, decoder result; all-zero means unmapped
- m_grant_onehot_o, out, M, current grant, registered
- tmo_flag_o, out, 1, sticky timeout indicator, cleared by reset only

Behaviour:
- Reset:
  - grant = 0; state IDLE; counters = 0; tmo_flag_o = 0.
  - All s_stb / s_cyc and all m_ack / m_err / m_rty = 0.
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - If any m_cyc is high, the arbiter picks a winner; grant is registered, so it is visible the next cycle; go to BUSY.
  - RR: the pointer advances to the index after the winner. FIXED: the lowest index wins.
- BUSY:
  - Granted master's fields are muxed to the slaves.
  - s_stb_o_all = s_sel_one_hot & {S{stb & cyc}}; s_cyc = granted cyc.
  - Responses are ORed across slaves and routed only to the granted master.
  - Grant is held while the granted master's cyc is high, including multi-beat bursts (CTI 010 to 111).
  - Granted cyc falls -> grant cleared -> IDLE.
  - Back-to-back ownership costs one idle cycle between owners.
- Decode error (BUSY, stb & cyc, s_sel_one_hot == 0):
  - No slave strobed; go to ERR.
  - ERR drives m_err to the granted master for exactly one cycle, then returns to BUSY.
  - A master still holding stb gets a repeated err every 2 cycles.
- Watchdog (TIMEOUT > 0):
  - Counts BUSY cycles with stb high and no ack/err/rty.
  - Clears on any response, on stb low, or on grant change.
  - When the count reaches TIMEOUT: s_stb forced low that cycle, go to ERR (one-cycle m_err), set tmo_flag_o.
  - A slave response arriving in the same cycle the count hits TIMEOUT wins: it is forwarded and there is no error.
- Simultaneous responses: multiple slave responses in one cycle are ORed (illegal by protocol, not checked).
- M == 1: arbiter bypassed; grant = m_cyc_i_all registered through the same FSM.
- Reset mid-transfer: all strobes and responses drop immediately (asynchronous); the in-flight transfer is lost.

Optional Feature:
- Macro: WB_BUS_TRACE_EN.
- Defined:
  - Adds outputs trigger (1) and trace (32).
  - trigger pulses one cycle on decode error or timeout.
  - trace = {error_type[1:0], granted master bin [7:0], slave bin [7:0], m_grant_addr[13:0]}, registered together with trigger.
- Undefined: ports absent; no extra logic.

Decomposition:
- Package wb_bus_pkg:
  - FSM state encoding.
  - ARB_MODE string constants.
  - Error-type codes (DEC = 2'b01, TMO = 2'b10).
  - log2 function.
- Sub-module wb_rr_fixed_arbiter (M, ARB_MODE):
  - Inputs: request, clk, reset, enable.
  - Output: one-hot grant.
- Muxes reuse the existing one-hot and binary mux blocks.

Test Plan:
- M=2, RR, both cyc held high from cycle 0 -> m0 granted in cycle 1; m0 drops cyc at cycle 5 -> m1 granted in cycle 7; next contention grants m0.
- FIXED mode, m2 and m0 request together -> m0 granted; m2 waits until m0 releases.
- Burst: m1 issues 4 beats (CTI 010, 010, 010, 111) while m0 requests -> all 4 acks to m1, no grant change until m1 cyc falls.
- Unmapped address (s_sel_one_hot = 0) -> all s_stb = 0, m_err pulses one cycle, repeats every 2 cycles while stb is held.
- TIMEOUT = 4, slave never acks -> m_err at the 4th stalled cycle, tmo_flag_o = 1 and stays set; ack in that same cycle instead -> ack only, flag stays 0.
- Reset driven low during an active write -> s_stb / s_cyc low within the same cycle; after release the bus is in IDLE with no grant.

Source files
------------

// File: rtl/wb_bus_pkg.sv
// Shared constants for the Wishbone shared bus: FSM encoding, arbitration modes,
// error-type codes and a ceil-log2 helper.
package wb_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam string ARB_RR    = "RR";
    localparam string ARB_FIXED = "FIXED";

    localparam logic [1:0] ERR_DEC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            r = ((32'd1 << k) < n) ? k + 1 : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_fixed_arbiter.sv
// Combinational one-hot arbiter with a registered round-robin pointer;
// in FIXED mode the pointer is ignored and the lowest index wins.
module wb_rr_fixed_arbiter
    import wb_bus_pkg::*;
#(
    parameter int    M        = 4,
    parameter string ARB_MODE = "RR"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] request,
    input  logic         enable,
    output logic [M-1:0] grant
);

    localparam int PW = (M > 1) ? log2(M) : 1;
    localparam bit IS_FIXED = (ARB_MODE == ARB_FIXED);
    localparam logic [M-1:0] ONE_M = {{(M-1){1'b0}}, 1'b1};

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_s;
    logic [M-1:0]  grant_s;
    logic          found_s;
    logic          take_s;
    int            idx_s;

    // Scan requests starting at the pointer; the first hit wins.
    always_comb begin
        grant_s = '0;
        win_s   = '0;
        found_s = 1'b0;
        take_s  = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < M; i++) begin
            idx_s   = IS_FIXED ? i : int'(ptr_q) + i;
            idx_s   = (idx_s >= M) ? idx_s - M : idx_s;
            take_s  = request[idx_s] & ~found_s;
            grant_s = grant_s | (take_s ? (ONE_M << idx_s) : '0);
            win_s   = take_s ? PW'(idx_s) : win_s;
            found_s = found_s | take_s;
        end
        ptr_d = ptr_q;
        if (enable && found_s && !IS_FIXED) begin
            ptr_d = (win_s == PW'(M - 1)) ? '0 : win_s + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/wishbone_bus_arb_tmo.sv
// Wishbone shared bus with registered arbitration, burst-hold, decode-error and
// watchdog-timeout responses. Optional trace port under WB_BUS_TRACE_EN.
module wishbone_bus_arb_tmo
    import wb_bus_pkg::*;
#(
    parameter int    M        = 4,
    parameter int    S        = 4,
    parameter int    Dw       = 32,
    parameter int    Aw       = 32,
    parameter int    SELw     = 4,
    parameter int    TAGw     = 3,
    parameter int    CTIw     = 3,
    parameter int    BTEw     = 2,
    parameter string ARB_MODE = "RR",
    parameter int    TIMEOUT  = 255,
    parameter int    TMOw     = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [Aw*S-1:0]   s_adr_o_all,
    output logic [Dw*S-1:0]   s_dat_o_all,
    output logic [SELw*S-1:0] s_sel_o_all,
    output logic [TAGw*S-1:0] s_tag_o_all,
    output logic [CTIw*S-1:0] s_cti_o_all,
    output logic [BTEw*S-1:0] s_bte_o_all,
    output logic [S-1:0]      s_we_o_all,
    output logic [S-1:0]      s_cyc_o_all,
    output logic [S-1:0]      s_stb_o_all,
    input  logic [Dw*S-1:0]   s_dat_i_all,
    input  logic [S-1:0]      s_ack_i_all,
    input  logic [S-1:0]      s_err_i_all,
    input  logic [S-1:0]      s_rty_i_all,
    input  logic [Aw*M-1:0]   m_adr_i_all,
    input  logic [Dw*M-1:0]   m_dat_i_all,
    input  logic [SELw*M-1:0] m_sel_i_all,
    input  logic [TAGw*M-1:0] m_tag_i_all,
    input  logic [CTIw*M-1:0] m_cti_i_all,
    input  logic [BTEw*M-1:0] m_bte_i_all,
    input  logic [M-1:0]      m_we_i_all,
    input  logic [M-1:0]      m_stb_i_all,
    input  logic [M-1:0]      m_cyc_i_all,
    output logic [Dw*M-1:0]   m_dat_o_all,
    output logic [M-1:0]      m_ack_o_all,
    output logic [M-1:0]      m_err_o_all,
    output logic [M-1:0]      m_rty_o_all,
    output logic [Aw-1:0]     m_grant_addr,
    input  logic [S-1:0]      s_sel_one_hot,
    output logic [M-1:0]      m_grant_onehot_o,
`ifdef WB_BUS_TRACE_EN
    output logic              trigger,
    output logic [31:0]       trace,
`endif
    output logic              tmo_flag_o
);

    logic [1:0]      state_q, state_d;
    logic [M-1:0]    grant_q, grant_d;
    logic [TMOw-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_flag_q, tmo_flag_d;
    logic [M-1:0]    arb_grant_s;

    logic [Aw-1:0]   g_adr_s;
    logic [Dw-1:0]   g_dat_s;
    logic [SELw-1:0] g_sel_s;
    logic [TAGw-1:0] g_tag_s;
    logic [CTIw-1:0] g_cti_s;
    logic [BTEw-1:0] g_bte_s;
    logic            g_we_s, g_stb_s, g_cyc_s;
    logic [Dw-1:0]   rdat_s;

    logic busy_s, err_st_s, req_s;
    logic any_ack_s, any_err_s, any_rty_s, any_rsp_s;
    logic dec_err_s, tmo_edge_s, tmo_hit_s;

    if (M == 1) begin : g_single
        assign arb_grant_s = m_cyc_i_all;
    end else begin : g_arb
        wb_rr_fixed_arbiter #(
            .M        (M),
            .ARB_MODE (ARB_MODE)
        ) u_arb (
            .clk     (clk),
            .reset   (reset),
            .request (m_cyc_i_all),
            .enable  (state_q == ST_IDLE),
            .grant   (arb_grant_s)
        );
    end

    // AND-OR one-hot mux of the granted master's fields and of slave read data.
    always_comb begin
        g_adr_s = '0; g_dat_s = '0; g_sel_s = '0; g_tag_s = '0;
        g_cti_s = '0; g_bte_s = '0; g_we_s = 1'b0; g_stb_s = 1'b0; g_cyc_s = 1'b0;
        rdat_s  = '0;
        for (int i = 0; i < M; i++) begin
            g_adr_s = g_adr_s | (m_adr_i_all[i*Aw +: Aw]     & {Aw{grant_q[i]}});
            g_dat_s = g_dat_s | (m_dat_i_all[i*Dw +: Dw]     & {Dw{grant_q[i]}});
            g_sel_s = g_sel_s | (m_sel_i_all[i*SELw +: SELw] & {SELw{grant_q[i]}});
            g_tag_s = g_tag_s | (m_tag_i_all[i*TAGw +: TAGw] & {TAGw{grant_q[i]}});
            g_cti_s = g_cti_s | (m_cti_i_all[i*CTIw +: CTIw] & {CTIw{grant_q[i]}});
            g_bte_s = g_bte_s | (m_bte_i_all[i*BTEw +: BTEw] & {BTEw{grant_q[i]}});
            g_we_s  = g_we_s  | (m_we_i_all[i]  & grant_q[i]);
            g_stb_s = g_stb_s | (m_stb_i_all[i] & grant_q[i]);
            g_cyc_s = g_cyc_s | (m_cyc_i_all[i] & grant_q[i]);
        end
        for (int j = 0; j < S; j++) begin
            rdat_s = rdat_s | (s_dat_i_all[j*Dw +: Dw] & {Dw{s_sel_one_hot[j]}});
        end
    end

    assign busy_s    = (state_q == ST_BUSY);
    assign err_st_s  = (state_q == ST_ERR);
    assign req_s     = g_stb_s & g_cyc_s;
    assign any_ack_s = |s_ack_i_all;
    assign any_err_s = |s_err_i_all;
    assign any_rty_s = |s_rty_i_all;
    assign any_rsp_s = any_ack_s | any_err_s | any_rty_s;
    assign dec_err_s = busy_s & req_s & (s_sel_one_hot == '0);

    // The TIMEOUT-th consecutive stalled cycle drops the strobe; a response in it still wins.
    if (TIMEOUT > 0) begin : g_wdt
        assign tmo_edge_s = busy_s & req_s & (tmo_cnt_q == TMOw'(TIMEOUT - 1));
        assign tmo_hit_s  = tmo_edge_s & ~any_rsp_s & ~dec_err_s;
    end else begin : g_no_wdt
        assign tmo_edge_s = 1'b0;
        assign tmo_hit_s  = 1'b0;
    end

    // Next-state logic for FSM, grant, watchdog counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tmo_flag_d = tmo_flag_q | tmo_hit_s;
        if ((TIMEOUT > 0) && busy_s && req_s && !any_rsp_s && !tmo_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + TMOw'(1);
        end else begin
            tmo_cnt_d = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i_all) begin
                    grant_d = arb_grant_s;
                    state_d = ST_BUSY;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!g_cyc_s) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (dec_err_s || tmo_hit_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ERR: begin
                state_d = ST_BUSY;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign s_adr_o_all = {S{g_adr_s}};
    assign s_dat_o_all = {S{g_dat_s}};
    assign s_sel_o_all = {S{g_sel_s}};
    assign s_tag_o_all = {S{g_tag_s}};
    assign s_cti_o_all = {S{g_cti_s}};
    assign s_bte_o_all = {S{g_bte_s}};
    assign s_we_o_all  = {S{g_we_s}};
    assign s_cyc_o_all = {S{g_cyc_s}};
    assign s_stb_o_all = s_sel_one_hot & {S{busy_s & req_s & ~tmo_edge_s}};

    assign m_dat_o_all      = {M{rdat_s}};
    assign m_ack_o_all      = grant_q & {M{busy_s & any_ack_s}};
    assign m_rty_o_all      = grant_q & {M{busy_s & any_rty_s}};
    assign m_err_o_all      = grant_q & {M{(busy_s & any_err_s) | err_st_s}};
    assign m_grant_addr     = g_adr_s;
    assign m_grant_onehot_o = grant_q;
    assign tmo_flag_o       = tmo_flag_q;

`ifdef WB_BUS_TRACE_EN
    logic           trig_q;
    logic [31:0]    trace_q;
    logic [7:0]     mbin_s, sbin_s;
    logic [1:0]     etype_s;
    logic [Aw+13:0] adr_ext_s;

    // Binary indices of the granted master and selected slave for the trace word.
    always_comb begin
        mbin_s = 8'd0;
        sbin_s = 8'd0;
        for (int i = 0; i < M; i++) begin
            mbin_s = mbin_s | (grant_q[i] ? 8'(i) : 8'd0);
        end
        for (int j = 0; j < S; j++) begin
            sbin_s = sbin_s | (s_sel_one_hot[j] ? 8'(j) : 8'd0);
        end
        etype_s   = dec_err_s ? ERR_DEC : (tmo_hit_s ? ERR_TMO : 2'b00);
        adr_ext_s = {14'd0, g_adr_s};
    end

    // Trigger pulse and trace capture on each bus error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q  <= 1'b0;
            trace_q <= 32'd0;
        end else begin
            trig_q  <= dec_err_s | tmo_hit_s;
            trace_q <= (dec_err_s | tmo_hit_s) ? {etype_s, mbin_s, sbin_s, adr_ext_s[13:0]} : trace_q;
        end
    end

    assign trigger = trig_q;
    assign trace   = trace_q;
`endif

endmodule
